// File: rtl/board_write_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : board_write_ctrl
//  Purpose  : Single-port board memory write controller. Arbitrates two
//             cell-write requesters (round-robin) and runs a whole-board
//             clear sweep, one memory write per cycle.
//  Options  : BOARD_WRITE_CTRL_BOUNDS_CHECK_EN - when defined, requests with
//             x >= X_SIZE or y >= Y_SIZE are acknowledged with err and are
//             not written. When undefined, err is tied low and every request
//             is written unchecked.
//  Revision : 1.0 - initial release
// ============================================================================
module board_write_ctrl #(
    parameter int                    X_SIZE       = 16,
    parameter int                    Y_SIZE       = 16,
    parameter int                    X_ADDR_WIDTH = 4,
    parameter int                    Y_ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH   = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear_req,
    output logic                               clear_busy,
    output logic                               clear_done,
    input  logic                               req0,
    input  logic [X_ADDR_WIDTH-1:0]            x0,
    input  logic [Y_ADDR_WIDTH-1:0]            y0,
    input  logic [DATA_WIDTH-1:0]              data0,
    input  logic                               req1,
    input  logic [X_ADDR_WIDTH-1:0]            x1,
    input  logic [Y_ADDR_WIDTH-1:0]            y1,
    input  logic [DATA_WIDTH-1:0]              data1,
    output logic                               ack0,
    output logic                               ack1,
    output logic                               err,
    output logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]              mem_write_data,
    output logic                               mem_w_nr
);

    localparam int ADDR_WIDTH = Y_ADDR_WIDTH + X_ADDR_WIDTH;

    // FSM encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    // Last column / row of the sweep
    localparam logic [X_ADDR_WIDTH-1:0] X_LAST = X_ADDR_WIDTH'(X_SIZE - 1);
    localparam logic [Y_ADDR_WIDTH-1:0] Y_LAST = Y_ADDR_WIDTH'(Y_SIZE - 1);

    // A one-cell board finishes its sweep on the very first write
    localparam logic SINGLE_CELL = (X_SIZE == 1) && (Y_SIZE == 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    logic [1:0]              r_state;
    logic [1:0]              w_state_nx;
    logic                    r_last;       // 1 = requester 1 granted last
    logic [X_ADDR_WIDTH-1:0] r_cx;
    logic [Y_ADDR_WIDTH-1:0] r_cy;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_w_nr;
    logic                    r_ack0;
    logic                    r_ack1;
    logic                    r_busy;
    logic                    r_done;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                    w_req_any;
    logic                    w_gnt1;
    logic                    w_grant;
    logic                    w_oob;
    logic [X_ADDR_WIDTH-1:0] w_x;
    logic [Y_ADDR_WIDTH-1:0] w_y;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    w_sweep_last;
    logic [X_ADDR_WIDTH-1:0] w_nx_cx;
    logic [Y_ADDR_WIDTH-1:0] w_nx_cy;
    logic                    w_nx_last;

    // Round-robin arbitration: on a tie the requester not granted last wins
    always_comb begin
        w_req_any = req0 | req1;
        w_gnt1    = req1 & (~req0 | ~r_last);
        w_x       = w_gnt1 ? x1    : x0;
        w_y       = w_gnt1 ? y1    : y0;
        w_data    = w_gnt1 ? data1 : data0;
        // A request is granted only in IDLE and only when no clear is asked
        w_grant   = (r_state == S_IDLE) && !clear_req && w_req_any;
    end

    // Sweep position arithmetic: x runs fastest, wraps into the next row
    always_comb begin
        w_sweep_last = (r_cx == X_LAST) && (r_cy == Y_LAST);
        if (r_cx == X_LAST) begin
            w_nx_cx = '0;
            w_nx_cy = r_cy + 1'b1;
        end else begin
            w_nx_cx = r_cx + 1'b1;
            w_nx_cy = r_cy;
        end
        w_nx_last = (w_nx_cx == X_LAST) && (w_nx_cy == Y_LAST);
    end

    // Next-state selection; clear_req outranks both requesters in IDLE
    always_comb begin
        w_state_nx = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (clear_req) begin
                    w_state_nx = S_CLEAR;
                end else if (w_req_any) begin
                    w_state_nx = S_WRITE;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_WRITE: begin
                w_state_nx = S_IDLE;
            end
            S_CLEAR: begin
                w_state_nx = w_sweep_last ? S_IDLE : S_CLEAR;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Last-granted pointer; moves only when a request is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_gnt1;
        end
    end

    // Sweep counters track the cell currently presented on mem_addr
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (r_state == S_IDLE && clear_req) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (r_state == S_CLEAR && !w_sweep_last) begin
            r_cx <= w_nx_cx;
            r_cy <= w_nx_cy;
        end
    end

    // Memory port and handshake outputs; address/data hold when not writing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_w_nr  <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_w_nr <= 1'b0;
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear_req) begin
                        r_w_nr  <= 1'b1;
                        r_addr  <= '0;
                        r_wdata <= CLEAR_VALUE;
                        r_busy  <= 1'b1;
                        r_done  <= SINGLE_CELL;
                    end else if (w_req_any) begin
                        r_ack0 <= ~w_gnt1;
                        r_ack1 <= w_gnt1;
                        if (!w_oob) begin
                            r_w_nr  <= 1'b1;
                            r_addr  <= {w_y, w_x};
                            r_wdata <= w_data;
                        end
                    end
                end
                S_CLEAR: begin
                    if (w_sweep_last) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_w_nr  <= 1'b1;
                        r_addr  <= {w_nx_cy, w_nx_cx};
                        r_wdata <= CLEAR_VALUE;
                        r_done  <= w_nx_last;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef BOARD_WRITE_CTRL_BOUNDS_CHECK_EN
    // Limits are one bit wider so a full-range size still compares correctly
    localparam logic [X_ADDR_WIDTH:0] X_LIMIT = (X_ADDR_WIDTH + 1)'(X_SIZE);
    localparam logic [Y_ADDR_WIDTH:0] Y_LIMIT = (Y_ADDR_WIDTH + 1)'(Y_SIZE);

    logic r_err;

    assign w_oob = ({1'b0, w_x} >= X_LIMIT) || ({1'b0, w_y} >= Y_LIMIT);

    // Reject flag accompanies the ack of an out-of-range request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_grant && w_oob;
        end
    end

    assign err = r_err;
`else
    assign w_oob = 1'b0;
    assign err   = 1'b0;
`endif

    assign mem_addr       = r_addr;
    assign mem_write_data = r_wdata;
    assign mem_w_nr       = r_w_nr;
    assign ack0           = r_ack0;
    assign ack1           = r_ack1;
    assign clear_busy     = r_busy;
    assign clear_done     = r_done;

endmodule
`default_nettype wire
